// File: rtl/mem_bus_bridge_pkg.sv
// mem_bus_bridge_pkg: shared widths, enables and bridge state encodings.
// Revision 1.0
`default_nettype none

package mem_bus_bridge_pkg;

  localparam int          RegBus            = 32;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic        ChipEnable        = 1'b1;
  localparam logic        WriteEnable       = 1'b1;
  localparam int          BusTimeoutDefault = 255;

  localparam int          BrgStateW = 2;
  localparam logic [1:0]  BrgIdle   = 2'd0;
  localparam logic [1:0]  BrgBusy   = 2'd1;
  localparam logic [1:0]  BrgDone   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mem_bus_bridge_timeout_cnt.sv
// bus_timeout_cnt: 8-bit cycle counter with clear/enable and a terminal-count flag.
// Revision 1.0
`default_nettype none

module bus_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  // tc marks the last permitted cycle, so the owner sees exactly LIMIT enabled cycles
  localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  assign tc_o = (count_q == LIMIT_M1);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: captures mem-stage load/store requests and runs them as req/ack bus cycles.
// Revision 1.0
`default_nettype none

module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT = BusTimeoutDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [RegBus-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [RegBus-1:0] mem_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [RegBus-1:0] mem_rdata_o,
  output logic              stallreq_o,
  output logic              bus_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [RegBus-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [RegBus-1:0] bus_wdata_o,
  input  logic [RegBus-1:0] bus_rdata_i,
  input  logic              bus_ack_i
);

  logic [BrgStateW-1:0] state_q, state_d;
  logic                 we_q, we_d;
  logic [RegBus-1:0]    addr_q, addr_d;
  logic [3:0]           sel_q, sel_d;
  logic [RegBus-1:0]    wdata_q, wdata_d;
  logic [RegBus-1:0]    rdata_q, rdata_d;
  logic                 drop_q, drop_d;
  logic                 err_q, err_d;

  logic accept;
  logic in_busy;
  logic tc;
  logic finish;
  logic drop_now;

  assign accept   = (state_q == BrgIdle) && (mem_ce_i == ChipEnable) && !flush_i;
  assign in_busy  = (state_q == BrgBusy);
  assign drop_now = drop_q | flush_i;
  assign finish   = in_busy && (bus_ack_i || tc);

  bus_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (in_busy),
    .tc_o  (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BrgIdle;
      we_q    <= 1'b0;
      addr_q  <= ZeroWord;
      sel_q   <= 4'b0000;
      wdata_q <= ZeroWord;
      rdata_q <= ZeroWord;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  // A flushed transaction still runs to completion on the bus but never reaches DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      BrgIdle: if (accept) state_d = BrgBusy;
      BrgBusy: if (finish) state_d = drop_now ? BrgIdle : BrgDone;
      BrgDone: if (!stall_i || flush_i) state_d = BrgIdle;
      default: state_d = BrgIdle;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    drop_d  = drop_q;
    err_d   = 1'b0;

    if (accept) begin
      we_d    = mem_we_i;
      addr_d  = mem_addr_i;
      sel_d   = mem_sel_i;
      wdata_d = mem_data_i;
      drop_d  = 1'b0;
    end

    if (in_busy) begin
      drop_d = drop_now;
      if (bus_ack_i) begin
        if (we_q != WriteEnable) rdata_d = bus_rdata_i;
      end else if (tc) begin
        rdata_d = ZeroWord;
        err_d   = !drop_now;
      end
      // Bus registers return to zero together with bus_req_o
      if (finish) begin
        we_d    = 1'b0;
        addr_d  = ZeroWord;
        sel_d   = 4'b0000;
        wdata_d = ZeroWord;
        drop_d  = 1'b0;
      end
    end
  end

  always_comb begin
    stallreq_o  = rst & (accept | in_busy);
    mem_rdata_o = (state_q == BrgDone) ? rdata_q : ZeroWord;
    bus_err_o   = err_q;
    bus_req_o   = in_busy;
    bus_we_o    = we_q;
    bus_addr_o  = addr_q;
    bus_sel_o   = sel_q;
    bus_wdata_o = wdata_q;
  end

endmodule

`default_nettype wire

// File: doc/mem_bus_bridge.md
# mem_bus_bridge

Sequential bridge between the combinational `mem` stage and the external data-memory bus. It captures each load/store request (address, byte selects, write data), runs it as a req/ack bus transaction with timeout, and holds the pipeline through `stallreq_o` until the access completes. It then presents the captured read word back to `mem` for exactly one advancing cycle. The block replaces the direct `mem` → data-RAM connection; `ctrl` consumes `stallreq_o`.

## Interface
- `TIMEOUT`, 255: cycles without `bus_ack_i` before the access is aborted; range 1..255.
- `clk` input 1: single clock.
- `rst` input 1: asynchronous, active-low reset.
- `mem_ce_i` input 1: access request from `mem` (`mem_ce_o`).
- `mem_we_i` input 1: 1 = store, 0 = load.
- `mem_addr_i` input 32: byte address; forwarded unchanged.
- `mem_sel_i` input 4: byte lanes, big-endian; bit 3 = bits 31:24 = address offset 0.
- `mem_data_i` input 32: store data, already lane-replicated by `mem`.
- `stall_i` input 1: `ctrl` is holding the `mem` stage (`stall[4]`).
- `flush_i` input 1: pipeline flush.
- `mem_rdata_o` output 32: load data returned to `mem`.
- `stallreq_o` output 1: request to stall the pipeline.
- `bus_err_o` output 1: one-cycle pulse when an access times out.
- `bus_req_o` output 1: bus request.
- `bus_we_o` output 1: bus write enable.
- `bus_addr_o` output 32: bus address.
- `bus_sel_o` output 4: bus byte enables.
- `bus_wdata_o` output 32: bus write data.
- `bus_rdata_i` input 32: bus read data, valid only with `bus_ack_i`.
- `bus_ack_i` input 1: transaction complete.

## Operation
- **States:** IDLE, BUSY, DONE (2-bit encoding).
- **IDLE**
  - If `mem_ce_i & !flush_i`: latch `mem_we_i`, `mem_addr_i`, `mem_sel_i`, `mem_data_i` into the bus registers, clear the timeout counter, go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - `bus_req_o` = 1; all bus outputs are held stable from registers.
  - Counter increments every cycle.
  - On `bus_ack_i`: if not a store, capture `bus_rdata_i` into `rdata_q`; go to DONE.
  - When counter reaches `TIMEOUT` without ack: `rdata_q` ← 0, pulse `bus_err_o`, go to DONE.
  - Ack and timeout in the same cycle: ack wins and no error is raised.
- **DONE**
  - Hold while `stall_i` = 1.
  - Go to IDLE when `stall_i` = 0 (the instruction advances this cycle) or when `flush_i` = 1.
- **Flush during BUSY:** the bus transaction is never aborted. Set a `drop` flag; on completion go to IDLE instead of DONE and suppress `bus_err_o`.
- **stallreq_o** = `(IDLE & mem_ce_i & !flush_i) | BUSY`.
  - Combinational from `mem_ce_i`; must not combinationally depend on `bus_ack_i`.
- **mem_rdata_o** = `rdata_q` in DONE, else 0.
  - Stores leave `rdata_q` unchanged.
  - `mem` performs lane extraction and sign extension (LB/LH/LWL/LWR/LL); the bridge returns the raw word.
- **Bus outputs**
  - `bus_we_o`, `bus_addr_o`, `bus_sel_o`, `bus_wdata_o` are registered.
  - They are zero whenever `bus_req_o` = 0.
- **SC with LLbit = 0:** `mem` drives `mem_ce_i` = 0, so no bus access starts.

## Timing
- **Reset (`rst` = 0, async):** state IDLE, counter 0, `drop` 0, `rdata_q` 0. All outputs 0.
- **Access sequence:**
  - Cycle 0: request seen, `stallreq_o` = 1.
  - Cycle 1: `bus_req_o` = 1.
  - Ack in cycle *k* ≥ 1 gives DONE in cycle *k*+1, with `stallreq_o` = 0 and data valid.
- **Minimum latency:** zero-wait slave gives 2 stall cycles.
- **Back-to-back accesses:** the next request is accepted in the IDLE cycle after DONE. There is one non-stalling cycle between accesses.
- **Timeout:** `bus_req_o` falls after `TIMEOUT` cycles in BUSY. `bus_err_o` is high in the first DONE cycle only.
- **Reset asserted mid-BUSY:** `bus_req_o` drops immediately; the slave must tolerate the abandoned request.

## Structure
- The shared define file gains:
  - state encodings `BrgIdle`, `BrgBusy`, `BrgDone`;
  - `BusTimeoutDefault`.
- Reuse the existing `RegBus`, `ZeroWord`, `ChipEnable`, `WriteEnable`.
- One natural sub-module: `bus_timeout_cnt` (8-bit counter with clear/enable/terminal-count flag).
- The FSM and registers live in the top module.
- Target size: about 150–200 lines.

## Test plan
- **LW, zero-wait:** addr 0x0000_0010, slave acks in cycle 1 with 0xDEAD_BEEF → `stallreq_o` high for 2 cycles; DONE cycle shows `mem_rdata_o` = 0xDEAD_BEEF, `bus_sel_o` was 4'b1111.
- **SB, 3 wait states:** addr 0x…0x1, data 0x5A5A_5A5A → `bus_sel_o` = 4'b0100, `bus_we_o` = 1 stable for 4 cycles; `stallreq_o` high for 5 cycles; `mem_rdata_o` = 0 in DONE.
- **Timeout:** `TIMEOUT` = 4, no ack → `bus_req_o` high for 4 cycles; single `bus_err_o` pulse; `mem_rdata_o` = 0; next request accepted.
- **Stall hold:** `stall_i` = 1 for 3 cycles in DONE → `mem_rdata_o` held, no new `bus_req_o`; IDLE after `stall_i` drops.
- **Flush in BUSY:** ack arrives 2 cycles later → no DONE cycle, no `bus_err_o`, `stallreq_o` low once the FSM returns to IDLE.
- **Async reset mid-BUSY:** `rst` low for a half-cycle → all outputs 0 immediately; state IDLE after release.
